// File: rtl/frisc_alu_pkg.sv
// rtl/frisc_alu_pkg.sv - ALU select encodings, funct3 codes and the operand bundle (ALU_OPERAND_ILLEGAL_EN)
package frisc_alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SHW   = $clog2(ALU_WIDTH);

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    typedef enum logic [7:0] {
        ALU_SEL_ADD  = 8'h01,
        ALU_SEL_SLL  = 8'h02,
        ALU_SEL_SLT  = 8'h04,
        ALU_SEL_SLTU = 8'h08,
        ALU_SEL_XOR  = 8'h10,
        ALU_SEL_SR   = 8'h20,
        ALU_SEL_OR   = 8'h40,
        ALU_SEL_AND  = 8'h80
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_e;

    typedef struct packed {
        alu_sel_e               sel;
        logic                   is_add;
        logic                   is_arith;
        logic [ALU_WIDTH-1:0]   a;
        logic [ALU_WIDTH-1:0]   b;
        logic [ALU_WIDTH-1:0]   shamt;
`ifdef ALU_OPERAND_ILLEGAL_EN
        logic                   illegal;
`endif
    } alu_bundle_t;

    function automatic alu_sel_e sel_from_funct3(input logic [2:0] funct3);
        case (funct3)
            F3_ADD_SUB: return ALU_SEL_ADD;
            F3_SLL:     return ALU_SEL_SLL;
            F3_SLT:     return ALU_SEL_SLT;
            F3_SLTU:    return ALU_SEL_SLTU;
            F3_XOR:     return ALU_SEL_XOR;
            F3_SRL_SRA: return ALU_SEL_SR;
            F3_OR:      return ALU_SEL_OR;
            default:    return ALU_SEL_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - upstream/ALU handshake bundle of the operand stage (ALU_OPERAND_ILLEGAL_EN)
interface alu_operand_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic             in_funct7b5;
    logic             in_is_imm;
    logic [WIDTH-1:0] in_rs1;
    logic [WIDTH-1:0] in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_sel;
    logic             out_is_add;
    logic             out_is_arith;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_shamt;
`ifdef ALU_OPERAND_ILLEGAL_EN
    logic             out_illegal;
`endif

    modport master (
        output in_valid, in_funct3, in_funct7b5, in_is_imm, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_sel, out_is_add, out_is_arith, out_a, out_b, out_shamt
`ifdef ALU_OPERAND_ILLEGAL_EN
        , input out_illegal
`endif
    );

    modport slave (
        input  in_valid, in_funct3, in_funct7b5, in_is_imm, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_sel, out_is_add, out_is_arith, out_a, out_b, out_shamt
`ifdef ALU_OPERAND_ILLEGAL_EN
        , output out_illegal
`endif
    );

endinterface

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational OP/OP-IMM decode into an ALU bundle (ALU_OPERAND_ILLEGAL_EN)
module alu_op_decode
    import frisc_alu_pkg::*;
(
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 is_imm,
    input  logic [ALU_WIDTH-1:0] rs1,
    input  logic [ALU_WIDTH-1:0] rs2,
    input  logic [ALU_WIDTH-1:0] imm,
    output alu_bundle_t          bundle
);
    logic [ALU_WIDTH-1:0] op_b;
`ifdef ALU_OPERAND_ILLEGAL_EN
    logic                 illegal;
`endif

    always_comb begin
        op_b            = is_imm ? imm : rs2;
        bundle          = '0;
        bundle.sel      = sel_from_funct3(funct3);
        // Bit 30 is immediate data for ADDI, so only register-form ADD can subtract.
        bundle.is_add   = !((funct3 == F3_ADD_SUB) && !is_imm && funct7b5);
        bundle.is_arith = (funct3 == F3_SRL_SRA) && funct7b5;
        bundle.a        = rs1;
        bundle.b        = op_b;
        bundle.shamt    = ALU_WIDTH'(op_b[ALU_SHW-1:0]);
`ifdef ALU_OPERAND_ILLEGAL_EN
        illegal = (!is_imm && funct7b5 && (funct3 != F3_ADD_SUB) && (funct3 != F3_SRL_SRA))
               || (is_imm && (funct3 == F3_SLL) && funct7b5)
               || (is_imm && (funct3 == F3_SRL_SRA) && (imm[11:5] != 7'h00) && (imm[11:5] != 7'h20));
        if (illegal) begin
            bundle.sel      = ALU_SEL_ADD;
            bundle.is_add   = 1'b1;
            bundle.is_arith = 1'b0;
        end
        bundle.illegal = illegal;
`endif
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ALU operand decode behind a 2-entry skid buffer (ALU_OPERAND_ILLEGAL_EN)
module alu_operand_stage
    import frisc_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave bus
);
    skid_state_e state_q, state_d;
    alu_bundle_t dec, main_q, skid_q;
    logic        main_valid, skid_valid, in_ready, accept;
    logic        load_main, main_from_skid, load_skid;

    alu_op_decode u_decode (
        .funct3   (bus.in_funct3),
        .funct7b5 (bus.in_funct7b5),
        .is_imm   (bus.in_is_imm),
        .rs1      (bus.in_rs1),
        .rs2      (bus.in_rs2),
        .imm      (bus.in_imm),
        .bundle   (dec)
    );

    // Valids are pure decodes of the state register, so in_ready never sees inputs.
    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_TWO);
    assign in_ready   = !skid_valid;
    assign accept     = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && bus.out_ready) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = ST_TWO;
                end else if (bus.out_ready) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (bus.out_ready) begin
                    main_from_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)           main_q <= dec;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= dec;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = main_valid;
    assign bus.out_sel      = main_q.sel;
    assign bus.out_is_add   = main_q.is_add;
    assign bus.out_is_arith = main_q.is_arith;
    assign bus.out_a        = WIDTH'(main_q.a);
    assign bus.out_b        = WIDTH'(main_q.b);
    assign bus.out_shamt    = WIDTH'(main_q.shamt);
`ifdef ALU_OPERAND_ILLEGAL_EN
    assign bus.out_illegal  = main_q.illegal;
`endif

endmodule
